// File: rtl/game_event_decoder_if.sv
// Signal bundle between the game core (master) and the event decoder (slave).
// The master drives the game inputs; the slave drives the decoded events, state and tone.
interface game_event_decoder_if;
    logic [1:0]  status;
    logic [15:0] score;
    logic [15:0] bird_y;
    logic [31:0] pipe1;
    logic [31:0] pipe2;
    logic [31:0] pipe3;
    logic [31:0] coin;

    logic [1:0]  game_state;
    logic        score_pulse;
    logic        coin_pulse;
    logic        wrap_pulse;
    logic        over_pulse;
    logic [15:0] high_score;
    logic [1:0]  tone;
    logic        tone_active;
    logic        bird_rising;

    modport master (
        output status, score, bird_y, pipe1, pipe2, pipe3, coin,
        input  game_state, score_pulse, coin_pulse, wrap_pulse, over_pulse,
               high_score, tone, tone_active, bird_rising
    );

    modport slave (
        input  status, score, bird_y, pipe1, pipe2, pipe3, coin,
        output game_state, score_pulse, coin_pulse, wrap_pulse, over_pulse,
               high_score, tone, tone_active, bird_rising
    );
endinterface

// File: rtl/game_event_decoder.sv
// Turns per-tick game snapshots into game state, one-tick event strobes and a buzzer tone.
// Every output is registered and follows the causing input sample by exactly one tick.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a running status and moving pipes
// RUN     | game in progress; events decoded, pipe1 stall monitored
// OVER    | pipe1 stalled for STALL_TICKS samples; held until restart
module game_event_decoder #(
    parameter int OVER_TICKS  = 10,
    parameter int COIN_TICKS  = 3,
    parameter int STALL_TICKS = 2
) (
    input  logic                  clk_100ms,
    input  logic                  rst,
    game_event_decoder_if.slave   bus
);

    localparam int BUZ_MAX = (OVER_TICKS > COIN_TICKS) ? OVER_TICKS : COIN_TICKS;
    localparam int BW      = $clog2(BUZ_MAX + 1);
    localparam int SW      = $clog2(STALL_TICKS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t      state;
    logic [SW-1:0] stall_cnt;
    logic [BW-1:0] buz_cnt;

    logic [15:0] prev_score;
    logic        prev_coin_v;
    logic [9:0]  prev_x1;
    logic [9:0]  prev_x2;
    logic [9:0]  prev_x3;

    logic [9:0]  x1;
    logic [9:0]  x2;
    logic [9:0]  x3;
    logic        restart;
    logic        in_run;
    logic        x1_same;
    logic        ev_over;
    logic        ev_score;
    logic        ev_coin;
    logic        ev_wrap;
    logic [1:0]  ev_tone;
    logic [BW-1:0] ev_len;
    logic        tone_load;

    assign x1 = bus.pipe1[19:10];
    assign x2 = bus.pipe2[19:10];
    assign x3 = bus.pipe3[19:10];

    assign restart  = (bus.status == 2'd1) || (bus.status == 2'd2);
    assign in_run   = (state == ST_RUN);
    assign x1_same  = (x1 == prev_x1);

    // A restart request wins over a stall in the same tick, so no over event then.
    assign ev_over  = in_run && !restart && x1_same && ((int'(stall_cnt) + 1) >= STALL_TICKS);
    assign ev_score = in_run && (bus.score > prev_score);
    assign ev_coin  = in_run && !bus.coin[31] && prev_coin_v;
    assign ev_wrap  = in_run && ((x1 > prev_x1) || (x2 > prev_x2) || (x3 > prev_x3));

    always_comb begin
        ev_tone = 2'd0;
        ev_len  = '0;
        if (ev_over) begin
            ev_tone = 2'd3;
            ev_len  = BW'(OVER_TICKS);
        end else if (ev_coin) begin
            ev_tone = 2'd2;
            ev_len  = BW'(COIN_TICKS);
        end else if (ev_score) begin
            ev_tone = 2'd1;
            ev_len  = BW'(1);
        end
    end

    // Tone code doubles as priority, so equal-or-higher comparison covers retrigger too.
    assign tone_load = (ev_tone != 2'd0) && (ev_tone >= bus.tone);

    assign bus.game_state = state;

    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            stall_cnt       <= '0;
            buz_cnt         <= '0;
            prev_score      <= '0;
            prev_coin_v     <= 1'b0;
            prev_x1         <= '0;
            prev_x2         <= '0;
            prev_x3         <= '0;
            bus.score_pulse <= 1'b0;
            bus.coin_pulse  <= 1'b0;
            bus.wrap_pulse  <= 1'b0;
            bus.over_pulse  <= 1'b0;
            bus.high_score  <= '0;
            bus.tone        <= 2'd0;
            bus.tone_active <= 1'b0;
            bus.bird_rising <= 1'b0;
        end else begin
            prev_score      <= bus.score;
            prev_coin_v     <= bus.coin[31];
            prev_x1         <= x1;
            prev_x2         <= x2;
            prev_x3         <= x3;
            bus.bird_rising <= bus.bird_y[15];

            bus.score_pulse <= ev_score;
            bus.coin_pulse  <= ev_coin;
            bus.wrap_pulse  <= ev_wrap;
            bus.over_pulse  <= ev_over;

            if (ev_over && (bus.score > bus.high_score)) begin
                bus.high_score <= bus.score;
            end

            if (restart) begin
                state     <= ST_IDLE;
                stall_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        stall_cnt <= '0;
                        if (!x1_same) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (ev_over) begin
                            state     <= ST_OVER;
                            stall_cnt <= '0;
                        end else if (x1_same) begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end else begin
                            stall_cnt <= '0;
                        end
                    end
                    ST_OVER: begin
                        stall_cnt <= '0;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        stall_cnt <= '0;
                    end
                endcase
            end

            if (tone_load) begin
                bus.tone        <= ev_tone;
                buz_cnt         <= ev_len;
                bus.tone_active <= 1'b1;
            end else if (buz_cnt > BW'(1)) begin
                buz_cnt <= buz_cnt - 1'b1;
            end else begin
                buz_cnt         <= '0;
                bus.tone        <= 2'd0;
                bus.tone_active <= 1'b0;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.bird_y[14:0],
                           bus.pipe1[31:20], bus.pipe1[9:0],
                           bus.pipe2[31:20], bus.pipe2[9:0],
                           bus.pipe3[31:20], bus.pipe3[9:0],
                           bus.coin[30:0]};

endmodule

// File: tb/tb_game_event_decoder.sv
// Directed bench for game_event_decoder: walks one full game, a restart and a reset mid-tone.
module tb_game_event_decoder;

    logic clk_100ms = 1'b0;
    logic rst       = 1'b1;
    int   n_cmp     = 0;
    int   n_err     = 0;

    game_event_decoder_if bus();

    game_event_decoder #(
        .OVER_TICKS  (10),
        .COIN_TICKS  (3),
        .STALL_TICKS (2)
    ) dut (
        .clk_100ms (clk_100ms),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk_100ms = ~clk_100ms;

    function automatic logic [31:0] pipe_w(input logic [9:0] x);
        return {4'h0, 8'd60, x, 10'd200};
    endfunction

    function automatic logic [31:0] coin_w(input logic v);
        return {v, 11'd0, 10'd150, 10'd300};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_100ms);
        #1;
    endtask

    initial begin
        bus.status = 2'd1;
        bus.score  = 16'd4;
        bus.bird_y = 16'h8000;
        bus.pipe1  = pipe_w(10'd210);
        bus.pipe2  = pipe_w(10'd0);
        bus.pipe3  = pipe_w(10'd0);
        bus.coin   = coin_w(1'b1);

        #1 rst = 1'b0;
        #2;
        chk("rst_state", 16'(bus.game_state), 16'd0);
        chk("rst_tone", 16'(bus.tone), 16'd0);
        chk("rst_tone_act", 16'(bus.tone_active), 16'd0);
        chk("rst_high", bus.high_score, 16'd0);
        chk("rst_bird", 16'(bus.bird_rising), 16'd0);
        chk("rst_pulses", 16'({bus.score_pulse, bus.coin_pulse, bus.wrap_pulse, bus.over_pulse}), 16'd0);
        @(negedge clk_100ms);
        rst = 1'b1;

        // restart status keeps IDLE while the previous-value registers fill
        tick();
        chk("s1_state", 16'(bus.game_state), 16'd0);
        chk("s1_bird", 16'(bus.bird_rising), 16'd1);

        bus.status = 2'd0;
        bus.bird_y = 16'd50;
        bus.pipe1  = pipe_w(10'd208);
        tick();
        chk("start_state", 16'(bus.game_state), 16'd1);
        chk("start_pulses", 16'({bus.score_pulse, bus.coin_pulse, bus.wrap_pulse, bus.over_pulse}), 16'd0);
        chk("start_bird", 16'(bus.bird_rising), 16'd0);

        bus.pipe1 = pipe_w(10'd206);
        bus.score = 16'd5;
        bus.coin  = coin_w(1'b0);
        tick();
        chk("sc_score_p", 16'(bus.score_pulse), 16'd1);
        chk("sc_coin_p", 16'(bus.coin_pulse), 16'd1);
        chk("sc_wrap_p", 16'(bus.wrap_pulse), 16'd0);
        chk("sc_tone1", 16'(bus.tone), 16'd2);
        chk("sc_act1", 16'(bus.tone_active), 16'd1);

        bus.pipe1 = pipe_w(10'd204);
        tick();
        chk("sc_score_p2", 16'(bus.score_pulse), 16'd0);
        chk("sc_coin_p2", 16'(bus.coin_pulse), 16'd0);
        chk("sc_tone2", 16'(bus.tone), 16'd2);

        bus.pipe1 = pipe_w(10'd202);
        tick();
        chk("sc_tone3", 16'(bus.tone), 16'd2);

        bus.pipe1 = pipe_w(10'd200);
        tick();
        chk("sc_tone_end", 16'(bus.tone), 16'd0);
        chk("sc_act_end", 16'(bus.tone_active), 16'd0);

        // double wrap plus a coin 0->1 edge, which must not pulse
        bus.pipe1 = pipe_w(10'd198);
        bus.pipe2 = pipe_w(10'd640);
        bus.pipe3 = pipe_w(10'd640);
        bus.coin  = coin_w(1'b1);
        tick();
        chk("wrap_p", 16'(bus.wrap_pulse), 16'd1);
        chk("coin_rise_p", 16'(bus.coin_pulse), 16'd0);

        bus.pipe1 = pipe_w(10'd100);
        bus.score = 16'd7;
        tick();
        chk("wrap_once", 16'(bus.wrap_pulse), 16'd0);
        chk("s7_score_p", 16'(bus.score_pulse), 16'd1);
        chk("s7_tone", 16'(bus.tone), 16'd1);

        tick();
        chk("stall1_state", 16'(bus.game_state), 16'd1);
        chk("stall1_over", 16'(bus.over_pulse), 16'd0);
        chk("score_tone_end", 16'(bus.tone), 16'd0);

        tick();
        chk("over_state", 16'(bus.game_state), 16'd2);
        chk("over_p", 16'(bus.over_pulse), 16'd1);
        chk("over_high", bus.high_score, 16'd7);
        chk("over_tone", 16'(bus.tone), 16'd3);
        chk("over_act", 16'(bus.tone_active), 16'd1);

        for (int i = 1; i < 10; i++) begin
            tick();
            chk($sformatf("over_tone_t%0d", i), 16'(bus.tone), 16'd3);
            chk($sformatf("over_p_t%0d", i), 16'(bus.over_pulse), 16'd0);
        end
        tick();
        chk("over_tone_end", 16'(bus.tone), 16'd0);
        chk("over_act_end", 16'(bus.tone_active), 16'd0);
        chk("over_hold", 16'(bus.game_state), 16'd2);

        bus.status = 2'd1;
        bus.score  = 16'd0;
        tick();
        chk("restart_state", 16'(bus.game_state), 16'd0);
        chk("restart_high", bus.high_score, 16'd7);
        chk("restart_score_p", 16'(bus.score_pulse), 16'd0);

        // second game ends with a lower score, so the best score holds
        bus.status = 2'd0;
        bus.pipe1  = pipe_w(10'd90);
        bus.score  = 16'd5;
        tick();
        chk("g2_state", 16'(bus.game_state), 16'd1);
        chk("g2_idle_score_p", 16'(bus.score_pulse), 16'd0);

        bus.score = 16'd3;
        tick();
        chk("g2_dec_score_p", 16'(bus.score_pulse), 16'd0);
        chk("g2_stall1", 16'(bus.game_state), 16'd1);

        tick();
        chk("g2_over_state", 16'(bus.game_state), 16'd2);
        chk("g2_over_p", 16'(bus.over_pulse), 16'd1);
        chk("g2_high_hold", bus.high_score, 16'd7);

        tick();
        chk("g2_tone", 16'(bus.tone), 16'd3);
        #2 rst = 1'b0;
        #1;
        chk("arst_tone", 16'(bus.tone), 16'd0);
        chk("arst_act", 16'(bus.tone_active), 16'd0);
        chk("arst_state", 16'(bus.game_state), 16'd0);
        chk("arst_high", bus.high_score, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/game_event_decoder.md
GAME_EVENT_DECODER -- requirements
Module: game_event_decoder

Interface
REQ-001 SHALL have parameter OVER_TICKS, default 10: buzzer duration in ticks for game-over tone.
REQ-002 SHALL have parameter COIN_TICKS, default 3: buzzer duration in ticks for coin tone.
REQ-003 SHALL have parameter STALL_TICKS, default 2: consecutive unchanged pipe1 x samples that declare game over.
REQ-004 SHALL have port clk_100ms, input, 1: game tick clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port status, input, 2: game mode word; 1/2 = restart (single/dual), 0/3 = running (single/dual).
REQ-007 SHALL have port score, input, 16: current game score.
REQ-008 SHALL have port bird_y, input, 16: bit15 = rising flag, bits 9:0 = bird bottom y.
REQ-009 SHALL have ports pipe1, pipe2, pipe3, input, 32 each: bits 27:20 gap, 19:10 x, 9:0 y; bits 31:28 ignored.
REQ-010 SHALL have port coin, input, 32: bit31 valid, bits 19:10 y, bits 9:0 x.
REQ-011 SHALL have port game_state, output, 2: 0 IDLE, 1 RUN, 2 OVER.
REQ-012 SHALL have ports score_pulse, coin_pulse, wrap_pulse, over_pulse, output, 1 each: single-tick event strobes.
REQ-013 SHALL have port high_score, output, 16: best score recorded at game over.
REQ-014 SHALL have ports tone, output, 2 (0 silent, 1 score, 2 coin, 3 over) and tone_active, output, 1.
REQ-015 SHALL have port bird_rising, output, 1: registered copy of bird_y[15].

Function
REQ-016 SHALL register previous-tick copies of score, coin[31], and the three pipe x fields; all detection compares current input to these copies.
REQ-017 SHALL assert all outputs exactly one tick after the input sample causing them (registered, latency 1).
REQ-018 SHALL implement FSM IDLE->RUN when status is 0 or 3 and pipe1 x differs from previous sample.
REQ-019 SHALL count consecutive RUN ticks with pipe1 x equal to previous sample; counter clears on any change; RUN->OVER when count reaches STALL_TICKS.
REQ-020 SHALL go to IDLE from any state when status is 1 or 2; this takes priority over all other transitions.
REQ-021 SHALL pulse over_pulse for one tick on the RUN->OVER transition only.
REQ-022 SHALL, on RUN->OVER, load high_score with score if score > high_score (unsigned), else hold.
REQ-023 SHALL pulse score_pulse in RUN when score > previous score (unsigned); score decrease or equality gives no pulse.
REQ-024 SHALL pulse coin_pulse in RUN when coin[31] is 0 and previous coin[31] was 1; 0->1 transitions give no pulse.
REQ-025 SHALL pulse wrap_pulse in RUN when any pipe x is greater than its previous value (respawn wrap); multiple simultaneous wraps give one pulse.
REQ-026 SHALL suppress all event pulses except over_pulse outside RUN; previous-value registers update every tick regardless of state.
REQ-027 SHALL run a buzzer sequencer with a down-counter: over event loads tone 3 for OVER_TICKS, coin event loads tone 2 for COIN_TICKS, score event loads tone 1 for 1 tick.
REQ-028 SHALL resolve simultaneous events by priority over > coin > score; a new event preempts an active tone only if higher or equal priority, reloading its counter.
REQ-029 SHALL drive tone_active high while counter nonzero; tone returns to 0 when counter expires.
REQ-030 SHALL reload the tone counter when a same-priority event occurs mid-tone (retrigger).

Reset
REQ-031 SHALL on rst low clear game_state to IDLE, all pulses, tone, tone_active, bird_rising, stall counter, buzzer counter, high_score, and previous-value registers to 0.
REQ-032 SHALL abort any active tone and FSM state immediately on rst assertion mid-operation.

Verification
REQ-033 Reset, then status=0 with pipe1 x 210->208 -> game_state=1 one tick later, no pulses.
REQ-034 RUN, score 4->5 and coin[31] 1->0 same tick -> score_pulse=1, coin_pulse=1, tone=2 for 3 ticks, then tone=0, tone_active=0.
REQ-035 RUN, pipe1 x held at 100 for 2 ticks with score=7, high_score=3 -> over_pulse=1, game_state=2, high_score=7, tone=3 for 10 ticks.
REQ-036 RUN, pipe2 x 0->640 and pipe3 x 0->640 same tick -> single wrap_pulse.
REQ-037 OVER, status=1 -> game_state=0 next tick; high_score retained at 7; score drop to 0 gives no score_pulse.
REQ-038 rst pulsed low during tone=3 -> tone=0, tone_active=0, game_state=0, high_score=0 immediately.
